framebuffer_cmd_sequencer: RTL and testbench
============================================

Name: framebuffer_cmd_sequencer

Overview:
- Sequences commands onto up to NUM_FB internal framebuffers (color, depth, stencil) through their apply/applied command interfaces.
- Accepts one host command at a time over a valid/ready handshake.
- Memset commands are broadcast to all selected framebuffers in parallel.
- Commit commands are serialized in index order (0 first), because the framebuffers share one downstream stream sink; streamSel tells the external AXIS mux which framebuffer is streaming.

Parameters:
- NUM_FB, 3, number of framebuffers controlled (1..8)
- FB_SIZE_IN_PIXEL_LG, 20, width of the stream size field
- SEL_WIDTH, $clog2(NUM_FB) (minimum 1), width of streamSel

Ports:
- aclk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- s_cmd_valid  input  1  host command valid
- s_cmd_ready  output  1  sequencer accepts command
- s_cmd_op  input  1  0 = memset, 1 = commit
- s_cmd_sel  input  NUM_FB  framebuffer select mask
- s_cmd_size  input  FB_SIZE_IN_PIXEL_LG  stream size (commit only)
- fbApply  output  NUM_FB  per-framebuffer apply
- fbApplied  input  NUM_FB  per-framebuffer applied (1 = idle)
- fbCmdCommit  output  1  shared commit bit
- fbCmdMemset  output  1  shared memset bit
- fbCmdSize  output  FB_SIZE_IN_PIXEL_LG  shared size
- streamSel  output  SEL_WIDTH  index of the committing framebuffer
- busy  output  1  command in progress
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; s_cmd_ready=1; fbApply=0; fbCmdCommit=0; fbCmdMemset=0; fbCmdSize=0; streamSel=0; busy=0; done=0.
- Reset asserted mid-command drops fbApply immediately. The framebuffers are not aborted; software must wait until they are idle again.
- States:
  - IDLE: s_cmd_ready=1. When s_cmd_valid=1, latch op, sel and size, go to ARB, and set busy=1 from the next cycle.
  - Empty sel is accepted: done pulses the cycle after acceptance and the state returns to IDLE with no apply issued.
  - ARB (memset): target = sel. Go to ISSUE once every target has fbApplied=1; otherwise wait.
  - ARB (commit): target = one-hot of the lowest remaining bit of sel, and streamSel = its index. Go to ISSUE once that target has fbApplied=1.
  - ISSUE: exactly one cycle of fbApply=target, with fbCmdMemset/fbCmdCommit set per op and fbCmdSize=latched size. Clear the per-channel "seenBusy" flags. Go to WAIT.
  - WAIT: fbApply=0. Command bits stay stable until the state returns to IDLE.
    - seenBusy[i] is set when target[i] has fbApplied[i]=0.
    - Leave WAIT when every target bit has seenBusy=1 and fbApplied=1.
    - Memset: leave to IDLE.
    - Commit: clear the served bit from the remaining sel. Go to ARB if bits remain, else IDLE.
  - Entering IDLE from WAIT pulses done=1 for one cycle and clears busy in the same cycle.
- Acceptance latency: fbApply rises no earlier than 2 cycles after acceptance (ARB then ISSUE). If the targets are already idle, it rises exactly then.
- s_cmd_ready=0 in every state except IDLE. A new command cannot be accepted in the cycle done pulses; the earliest acceptance is the following cycle.
- streamSel holds its value from ARB through WAIT of each commit. It keeps its last value while idle and during memset.
- A target whose fbApplied never drops hangs the sequencer in WAIT by design; there is no timeout.
- Select bits at or above NUM_FB do not exist, since s_cmd_sel is exactly NUM_FB wide.

Test Plan:
- Memset, sel=3'b111, all applied=1, each model busy for 10 cycles → one cycle of fbApply=3'b111 with fbCmdMemset=1; done pulses once, after the last model returns applied=1.
- Commit, sel=3'b101, size=0x4B000 → fbApply=3'b001 with streamSel=0 and fbCmdSize=0x4B000; after model 0 completes, fbApply=3'b100 with streamSel=2; exactly one done pulse at the end.
- Memset, sel=3'b010, with fbApplied[1]=0 initially for 5 cycles → no apply until fbApplied[1] rises; then a single apply pulse.
- sel=0 with s_cmd_valid held → accepted, done pulses the next cycle, fbApply stays 0, s_cmd_ready back to 1 the cycle after done.
- resetn pulsed low during WAIT of a commit → all outputs return to reset values asynchronously; after release the next command is accepted normally.
- Back-to-back commands (s_cmd_valid held high) → second command accepted exactly one cycle after the first done pulse; no overlap of apply pulses.

Source files
------------

// File: rtl/framebuffer_cmd_sequencer.sv
// Host command sequencer for NUM_FB framebuffers: memsets are broadcast,
// commits are issued one framebuffer at a time (lowest index first) over a shared stream.
module framebuffer_cmd_sequencer #(
  parameter int NUM_FB              = 3,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int SEL_WIDTH           = (NUM_FB > 1) ? $clog2(NUM_FB) : 1
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic                           s_cmd_valid,
  output logic                           s_cmd_ready,
  input  logic                           s_cmd_op,
  input  logic [NUM_FB-1:0]              s_cmd_sel,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] s_cmd_size,
  output logic [NUM_FB-1:0]              fbApply,
  input  logic [NUM_FB-1:0]              fbApplied,
  output logic                           fbCmdCommit,
  output logic                           fbCmdMemset,
  output logic [FB_SIZE_IN_PIXEL_LG-1:0] fbCmdSize,
  output logic [SEL_WIDTH-1:0]           streamSel,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_e;

  state_e                           state_q, state_d;
  logic                             op_q, op_d;
  logic [NUM_FB-1:0]                sel_q, sel_d;
  logic [NUM_FB-1:0]                target_q, target_d;
  logic [NUM_FB-1:0]                seen_q, seen_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0]   size_q, size_d;
  logic [SEL_WIDTH-1:0]             stream_sel_q, stream_sel_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             cmd_commit_q, cmd_commit_d;
  logic                             cmd_memset_q, cmd_memset_d;
  logic [NUM_FB-1:0]                rem_sel;

  function automatic logic [NUM_FB-1:0] low_onehot(input logic [NUM_FB-1:0] m);
    return m & (~m + NUM_FB'(1));
  endfunction

  function automatic logic [SEL_WIDTH-1:0] low_index(input logic [NUM_FB-1:0] m);
    logic [SEL_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_FB - 1; i >= 0; i--)
      if (m[i]) idx = SEL_WIDTH'(i);
    return idx;
  endfunction

  // done_q blocks acceptance so the completion pulse and a new accept never coincide
  assign s_cmd_ready = (state_q == IDLE) && !done_q;
  assign fbApply     = (state_q == ISSUE) ? target_q : '0;
  assign fbCmdCommit = cmd_commit_q;
  assign fbCmdMemset = cmd_memset_q;
  assign fbCmdSize   = size_q;
  assign streamSel   = stream_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rem_sel     = sel_q & ~target_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sel_d        = sel_q;
    target_d     = target_q;
    seen_d       = seen_q;
    size_d       = size_q;
    stream_sel_d = stream_sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cmd_commit_d = cmd_commit_q;
    cmd_memset_d = cmd_memset_q;
    case (state_q)
      IDLE: begin
        if (s_cmd_valid && s_cmd_ready) begin
          op_d   = s_cmd_op;
          sel_d  = s_cmd_sel;
          size_d = s_cmd_size;
          if (s_cmd_sel == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ARB;
            busy_d  = 1'b1;
            if (s_cmd_op) begin
              target_d     = low_onehot(s_cmd_sel);
              stream_sel_d = low_index(s_cmd_sel);
            end else begin
              target_d = s_cmd_sel;
            end
          end
        end
      end
      ARB: begin
        if ((target_q & ~fbApplied) == '0) begin
          state_d      = ISSUE;
          cmd_commit_d = op_q;
          cmd_memset_d = !op_q;
        end
      end
      ISSUE: begin
        seen_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        seen_d = seen_q | (target_q & ~fbApplied);
        // a target must have been observed busy before its idle counts as completion
        if ((target_q & ~(seen_q & fbApplied)) == '0) begin
          if (op_q && rem_sel != '0) begin
            state_d      = ARB;
            sel_d        = rem_sel;
            target_d     = low_onehot(rem_sel);
            stream_sel_d = low_index(rem_sel);
          end else begin
            state_d      = IDLE;
            sel_d        = rem_sel;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            cmd_commit_d = 1'b0;
            cmd_memset_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      sel_q        <= '0;
      target_q     <= '0;
      seen_q       <= '0;
      size_q       <= '0;
      stream_sel_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_commit_q <= 1'b0;
      cmd_memset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sel_q        <= sel_d;
      target_q     <= target_d;
      seen_q       <= seen_d;
      size_q       <= size_d;
      stream_sel_q <= stream_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_commit_q <= cmd_commit_d;
      cmd_memset_q <= cmd_memset_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_cmd_sequencer.sv
// Bench for framebuffer_cmd_sequencer: framebuffer models with programmable busy time,
// expected apply sequence and timing derived from the command rules.
module tb_framebuffer_cmd_sequencer;
  localparam int N = 3, SW = 20, SELW = 2;

  logic          aclk = 1'b0, resetn = 1'b0;
  logic          s_cmd_valid = 1'b0, s_cmd_ready, s_cmd_op = 1'b0;
  logic [N-1:0]  s_cmd_sel = '0;
  logic [SW-1:0] s_cmd_size = '0;
  logic [N-1:0]  fbApply, fbApplied;
  logic          fbCmdCommit, fbCmdMemset, busy, done;
  logic [SW-1:0] fbCmdSize;
  logic [SELW-1:0] streamSel;

  always #5 aclk = ~aclk;

  framebuffer_cmd_sequencer #(.NUM_FB(N), .FB_SIZE_IN_PIXEL_LG(SW)) dut (
    .aclk(aclk), .resetn(resetn), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_op(s_cmd_op), .s_cmd_sel(s_cmd_sel), .s_cmd_size(s_cmd_size),
    .fbApply(fbApply), .fbApplied(fbApplied), .fbCmdCommit(fbCmdCommit),
    .fbCmdMemset(fbCmdMemset), .fbCmdSize(fbCmdSize), .streamSel(streamSel),
    .busy(busy), .done(done));

  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge aclk) cyc++;

  // framebuffer models: busy for blen[i] cycles after seeing an apply
  int cnt[N] = '{default: 0};
  int blen[N] = '{default: 4};
  logic [N-1:0] hold = '0;
  always_comb begin
    fbApplied = '0;
    for (int i = 0; i < N; i++) fbApplied[i] = (cnt[i] == 0) && !hold[i];
  end
  always @(negedge aclk)
    for (int i = 0; i < N; i++)
      if (fbApply[i]) cnt[i] = blen[i];
      else if (cnt[i] > 0) cnt[i]--;

  // monitor
  logic [N-1:0]  ev_mask[$];
  int            ev_ss[$], ev_cyc[$];
  logic [1:0]    ev_op[$];
  logic [SW-1:0] ev_size[$];
  int            done_cyc[$];
  logic [1:0]    done_info[$];
  logic          rdy_after[$];
  logic          prev_done = 1'b0;
  always @(negedge aclk) begin
    if (fbApply != '0) begin
      ev_mask.push_back(fbApply); ev_ss.push_back(int'(streamSel)); ev_cyc.push_back(cyc);
      ev_op.push_back({fbCmdMemset, fbCmdCommit}); ev_size.push_back(fbCmdSize);
    end
    if (prev_done) rdy_after.push_back(s_cmd_ready);
    if (done) begin done_cyc.push_back(cyc); done_info.push_back({busy, s_cmd_ready}); end
    prev_done = done;
  end

  task automatic tick(); @(negedge aclk); #1; endtask

  task automatic clear_q();
    ev_mask.delete(); ev_ss.delete(); ev_cyc.delete(); ev_op.delete(); ev_size.delete();
    done_cyc.delete(); done_info.delete(); rdy_after.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (fbApplied != '1 && k < 100) begin tick(); k++; end
    chk("fb_idle_timeout", 32'(k < 100), 1);
  endtask

  task automatic issue(input bit op, input logic [N-1:0] sel, input logic [SW-1:0] size, output int acc);
    int k = 0;
    s_cmd_valid = 1'b1; s_cmd_op = op; s_cmd_sel = sel; s_cmd_size = size;
    while (!s_cmd_ready && k < 200) begin tick(); k++; end
    chk("accept_timeout", 32'(k < 200), 1);
    acc = cyc + 1;
    tick();
  endtask

  int last_ss = 0;

  // expected: memset -> one apply of sel; commit -> one apply per set bit, low first
  task automatic check_cmd(string nm, bit op, logic [N-1:0] sel, logic [SW-1:0] size, int acc, int exp_first);
    logic [N-1:0] em[$];
    int es[$];
    int k = 0, lmax = 0, n, last;
    if (sel != '0) begin
      if (!op) begin em.push_back(sel); es.push_back(last_ss); end
      else for (int i = 0; i < N; i++) if (sel[i]) begin em.push_back(N'(1) << i); es.push_back(i); end
    end
    for (int i = 0; i < N; i++) if (sel[i] && blen[i] > lmax) lmax = blen[i];
    while (done_cyc.size() == 0 && k < 600) begin tick(); k++; end
    chk({nm, "_done_timeout"}, 32'(done_cyc.size() != 0), 1);
    if (done_cyc.size() == 0) begin clear_q(); return; end
    tick();
    chk({nm, "_n_apply"}, ev_mask.size(), em.size());
    n = (ev_mask.size() < em.size()) ? ev_mask.size() : em.size();
    for (int j = 0; j < n; j++) begin
      chk({nm, "_mask"}, 32'(ev_mask[j]), 32'(em[j]));
      chk({nm, "_ss"}, ev_ss[j], es[j]);
      chk({nm, "_cmd_bits"}, 32'(ev_op[j]), {30'd0, !op, op});
      chk({nm, "_size"}, 32'(ev_size[j]), 32'(size));
      if (j == 0) chk({nm, "_lat_first"}, ev_cyc[0], exp_first);
      else chk({nm, "_lat_next"}, ev_cyc[j], ev_cyc[j-1] + blen[es[j-1]] + 2);
    end
    if (em.size() == 0) chk({nm, "_done_cyc"}, done_cyc[0], acc);
    else if (ev_mask.size() >= em.size()) begin
      last = em.size() - 1;
      chk({nm, "_done_cyc"}, done_cyc[0], ev_cyc[last] + (op ? blen[es[last]] : lmax) + 1);
    end
    chk({nm, "_busy_ready_at_done"}, 32'(done_info[0]), 0);
    chk({nm, "_ready_after_done"}, 32'(rdy_after.size() > 0 && rdy_after[0]), 1);
    chk({nm, "_n_done"}, done_cyc.size(), 1);
    if (op && sel != '0) last_ss = es[es.size()-1];
    clear_q();
  endtask

  task automatic run(string nm, bit op, logic [N-1:0] sel, logic [SW-1:0] size);
    int acc;
    wait_idle();
    issue(op, sel, size, acc);
    s_cmd_valid = 1'b0;
    check_cmd(nm, op, sel, size, acc, acc + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_b, rel, k;
    #12;
    chk("rst_ready", 32'(s_cmd_ready), 1);
    chk("rst_apply", 32'(fbApply), 0);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_cmd", {fbCmdCommit, fbCmdMemset, 10'd0, fbCmdSize}, 0);
    chk("rst_ss", 32'(streamSel), 0);
    tick(); resetn = 1'b1; tick();

    blen = '{10, 10, 10};
    run("memset111", 1'b0, 3'b111, 20'h12345);
    blen = '{6, 3, 7};
    run("commit101", 1'b1, 3'b101, 20'h4B000);

    // fb1 held busy before the command arrives
    wait_idle();
    hold = 3'b010;
    issue(1'b0, 3'b010, 20'h00ABC, acc);
    s_cmd_valid = 1'b0;
    repeat (5) tick();
    rel = cyc; hold = '0;
    check_cmd("memset_wait", 1'b0, 3'b010, 20'h00ABC, acc, rel + 1);

    // empty select, valid held until acceptance
    wait_idle();
    issue(1'b1, 3'b000, 20'h1, acc);
    s_cmd_valid = 1'b0;
    check_cmd("empty_sel", 1'b1, 3'b000, 20'h1, acc, 0);

    // reset during WAIT of a commit
    blen = '{8, 8, 8};
    wait_idle();
    issue(1'b1, 3'b101, 20'h4B000, acc);
    s_cmd_valid = 1'b0;
    k = 0;
    while (ev_mask.size() == 0 && k < 50) begin tick(); k++; end
    tick(); tick();
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_apply", 32'(fbApply), 0);
    chk("mid_rst_ready", 32'(s_cmd_ready), 1);
    chk("mid_rst_busy_done", {30'd0, busy, done}, 0);
    chk("mid_rst_cmd", {fbCmdCommit, fbCmdMemset, 10'd0, fbCmdSize}, 0);
    chk("mid_rst_ss", 32'(streamSel), 0);
    tick(); resetn = 1'b1; last_ss = 0; clear_q();
    run("post_rst_memset", 1'b0, 3'b011, 20'h00777);
    run("post_rst_commit", 1'b1, 3'b100, 20'h00100);

    // back-to-back: valid stays high across both commands
    blen = '{4, 5, 6};
    wait_idle();
    issue(1'b0, 3'b011, 20'h00011, acc);
    issue(1'b1, 3'b110, 20'h00022, acc_b);
    s_cmd_valid = 1'b0;
    chk("b2b_acc", acc_b, (done_cyc.size() > 0) ? done_cyc[0] + 2 : -1);
    k = 0;
    while (done_cyc.size() < 2 && k < 200) begin tick(); k++; end
    chk("b2b_n_done", done_cyc.size(), 2);
    chk("b2b_n_apply", ev_mask.size(), 3);
    if (ev_mask.size() == 3 && done_cyc.size() == 2) begin
      chk("b2b_mask0", 32'(ev_mask[0]), 3'b011);
      chk("b2b_mask1", 32'(ev_mask[1]), 3'b010);
      chk("b2b_mask2", 32'(ev_mask[2]), 3'b100);
      chk("b2b_lat", ev_cyc[1], acc_b + 1);
      chk("b2b_no_overlap", 32'(ev_cyc[1] > done_cyc[0]), 1);
      last_ss = 2;
    end
    tick(); clear_q();

    // randomized commands
    for (int t = 0; t < 30; t++) begin
      bit op;
      logic [N-1:0] sel;
      wait_idle();
      for (int i = 0; i < N; i++) blen[i] = $urandom_range(2, 12);
      op  = 1'($urandom_range(0, 1));
      sel = N'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) tick();
      run($sformatf("rnd%0d", t), op, sel, SW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
